// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes, flag bit indices and mul/div FSM states
package alu_pkg;
  localparam int OP_DIV = 0;
  localparam int OP_MUL = 1;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG = 1;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_DBZ = 3;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
endpackage

// File: rtl/alu_muldiv_step.sv
// alu_muldiv_step: one unsigned shift-add multiply or restoring shift-subtract divide iteration
module alu_muldiv_step #(
  parameter int l = 16
) (
  input  logic           mul,
  input  logic [2*l-1:0] acc,
  input  logic [2*l-1:0] x,
  input  logic [l-1:0]   y,
  output logic [2*l-1:0] acc_n,
  output logic [2*l-1:0] x_n,
  output logic [l-1:0]   y_n
);
  logic [l:0] t;
  logic       ge;
  // multiply: acc += x when multiplier lsb set; divide: acc is partial remainder, y shifts dividend out and quotient in
  always_comb begin
    t = {acc[l-1:0], y[l-1]} - {1'b0, x[l-1:0]};
    ge = ~t[l];
    acc_n = mul ? (y[0] ? acc + x : acc) : {{l{1'b0}}, ge ? t[l-1:0] : {acc[l-2:0], y[l-1]}};
    x_n = mul ? x << 1 : x;
    y_n = mul ? y >> 1 : {y[l-2:0], ge};
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative signed multiply/divide with valid/ready handshake; ALU_MULDIV_EARLY_OUT_EN enables multiply early exit
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int l = 16,
  parameter int p = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [p:0]          operation,
  input  logic signed [l-1:0] a,
  input  logic signed [l-1:0] b,
  input  logic [l-1:0]        flags_in,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic signed [l-1:0] r,
  output logic signed [l-1:0] hi,
  output logic [l-1:0]        flags_out
);
  localparam int cw = $clog2(l + 1);
  state_t         state;
  logic [cw-1:0]  cnt;
  logic           mul, sa, sb, dbz;
  logic [2*l-1:0] acc, x, acc_n, x_n, prod;
  logic [l-1:0]   y, y_n, ma, mb, quo, rem, rn, hn, fo;
  logic [l-5:0]   fi;
  logic           op_mul, b_zero, ovf, last;
  alu_muldiv_step #(.l(l)) u_step (
    .mul(mul), .acc(acc), .x(x), .y(y), .acc_n(acc_n), .x_n(x_n), .y_n(y_n)
  );
  assign req_ready = state == S_IDLE;
  assign rsp_valid = state == S_DONE;
  // operand magnitudes at capture and signed fix-up of the final iteration's result
  always_comb begin
    op_mul = operation == (p+1)'(OP_MUL);
    b_zero = b == '0;
    ma = a[l-1] ? -a : a;
    mb = b[l-1] ? -b : b;
    prod = (sa ^ sb) ? -acc_n : acc_n;
    quo = (sa ^ sb) ? -y_n : y_n;
    rem = sa ? -acc_n[l-1:0] : acc_n[l-1:0];
    rn = dbz ? '1 : mul ? prod[l-1:0] : quo;
    hn = dbz ? (sa ? -y : y) : mul ? prod[2*l-1:l] : rem;
    ovf = dbz ? 1'b0 : mul ? (|prod[2*l-1:l-1]) & ~(&prod[2*l-1:l-1]) : ~(sa ^ sb) & y_n[l-1];
    fo = '0;
    fo[l-1:4] = fi;
    fo[FLAG_ZERO] = rn == '0;
    fo[FLAG_NEG] = rn[l-1];
    fo[FLAG_OVF] = ovf;
    fo[FLAG_DBZ] = dbz;
`ifdef ALU_MULDIV_EARLY_OUT_EN
    last = cnt == cw'(1) || (mul && y_n == '0);
`else
    last = cnt == cw'(1);
`endif
  end
  // request capture, iteration and response hold; divide by zero spends a single calc cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      {mul, sa, sb, dbz} <= '0;
      acc <= '0;
      x <= '0;
      y <= '0;
      fi <= '0;
      r <= '0;
      hi <= '0;
      flags_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          mul <= op_mul;
          sa <= a[l-1];
          sb <= b[l-1];
          dbz <= !op_mul && b_zero;
          fi <= flags_in[l-1:4];
          acc <= '0;
          x <= {{l{1'b0}}, op_mul ? ma : mb};
          y <= op_mul ? mb : ma;
          cnt <= (!op_mul && b_zero) ? cw'(1) : cw'(l);
          state <= S_CALC;
        end
        S_CALC: begin
          acc <= acc_n;
          x <= x_n;
          y <= y_n;
          cnt <= cnt - cw'(1);
          if (last) begin
            r <= rn;
            hi <= hn;
            flags_out <= fo;
            state <= S_DONE;
          end
        end
        S_DONE: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed table, handshake/reset corner cases and random checks against an arithmetic model at l=5
module tb_alu_muldiv_seq;
`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [0:0] operation = '0;
  logic [4:0] a = '0, b = '0, flags_in = '0;
  logic       req_ready, rsp_valid;
  logic [4:0] r, hi, flags_out;
  int n_cmp = 0, n_bad = 0;

  typedef struct {
    bit op; logic [4:0] a, b, r, hi, fl; int lat;
  } vec_t;
  vec_t tbl[12];

  alu_muldiv_seq #(.l(5), .p(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .operation(operation), .a(a), .b(b), .flags_in(flags_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .r(r), .hi(hi), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input bit op, input logic [4:0] va, input logic [4:0] vb,
                                input logic [4:0] fin, output logic [4:0] er,
                                output logic [4:0] ehi, output logic [4:0] efl, output int lat);
    int ia, ib, pr, q, m, mag;
    bit ov, dz;
    ia = int'($signed(va));
    ib = int'($signed(vb));
    ov = 0;
    dz = 0;
    if (op) begin
      pr = ia * ib;
      er = pr[4:0];
      ehi = pr[9:5];
      ov = pr < -16 || pr > 15;
      mag = ib < 0 ? -ib : ib;
      lat = 1;
      for (int k = 0; k < 5; k++) if ((mag >> k) & 1) lat = k + 1;
      if (!EO) lat = 5;
    end else if (ib == 0) begin
      er = 5'h1f;
      ehi = va;
      dz = 1;
      lat = 1;
    end else if (ia == -16 && ib == -1) begin
      er = 5'h10;
      ehi = 5'h00;
      ov = 1;
      lat = 5;
    end else begin
      q = ia / ib;
      m = ia % ib;
      er = q[4:0];
      ehi = m[4:0];
      lat = 5;
    end
    efl = {fin[4], dz, ov, er[4], er == 5'h00};
  endfunction

  task automatic run(input string nm, input bit op, input logic [4:0] va, input logic [4:0] vb,
                     input logic [4:0] fin, input logic [4:0] er, input logic [4:0] ehi,
                     input logic [4:0] efl, input int elat, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({nm, " ready"}, 32'(req_ready), 32'd1);
    operation = op; a = va; b = vb; flags_in = fin; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    a = 5'($urandom); b = 5'($urandom); flags_in = 5'($urandom);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({nm, " latency"}, 32'(n), 32'(elat));
    chk({nm, " r"}, 32'(r), 32'(er));
    chk({nm, " hi"}, 32'(hi), 32'(ehi));
    chk({nm, " flags"}, 32'(flags_out), 32'(efl));
    for (int k = 0; k < hold; k++) begin
      req_valid = (k % 2) == 0;
      a = 5'($urandom); b = 5'($urandom);
      @(posedge clk); #1;
      chk({nm, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " hold ready"}, 32'(req_ready), 32'd0);
      chk({nm, " hold r"}, 32'(r), 32'(er));
      chk({nm, " hold hi"}, 32'(hi), 32'(ehi));
      chk({nm, " hold flags"}, 32'(flags_out), 32'(efl));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (hold > 0) begin
      chk({nm, " released valid"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk({nm, " no second capture"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    logic [4:0] er, ehi, efl, ra, rb, rf;
    bit rop;
    int lat;
    tbl = '{
      '{1'b0, 5'd6,       5'd3,       5'd2,       5'd0,       5'b00000, 5},
      '{1'b0, 5'd6,       5'd4,       5'd1,       5'd2,       5'b00000, 5},
      '{1'b0, 5'(-6),     5'd3,       5'(-2),     5'd0,       5'b00010, 5},
      '{1'b0, 5'(-16),    5'(-1),     5'(-16),    5'd0,       5'b00110, 5},
      '{1'b0, 5'd6,       5'd0,       5'(-1),     5'd6,       5'b01010, 1},
      '{1'b1, 5'd6,       5'd6,       5'd4,       5'd1,       5'b00100, EO ? 3 : 5},
      '{1'b1, 5'(-16),    5'(-1),     5'(-16),    5'd0,       5'b00110, EO ? 1 : 5},
      '{1'b1, 5'd2,       5'd3,       5'd6,       5'd0,       5'b00000, EO ? 2 : 5},
      '{1'b0, 5'd7,       5'(-2),     5'(-3),     5'd1,       5'b00010, 5},
      '{1'b0, 5'(-7),     5'd2,       5'(-3),     5'(-1),     5'b00010, 5},
      '{1'b1, 5'(-3),     5'd5,       5'(-15),    5'(-1),     5'b00010, EO ? 3 : 5},
      '{1'b1, 5'd0,       5'd7,       5'd0,       5'd0,       5'b00001, EO ? 3 : 5}
    };
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset valid", 32'(rsp_valid), 32'd0);
    chk("reset r", 32'(r), 32'd0);
    chk("reset hi", 32'(hi), 32'd0);
    chk("reset flags", 32'(flags_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (tbl[i])
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, 5'd0,
          tbl[i].r, tbl[i].hi, tbl[i].fl, tbl[i].lat, 0);
    run("hold", 1'b1, 5'd6, 5'd6, 5'd0, 5'd4, 5'd1, 5'b00100, EO ? 3 : 5, 3);
    operation = 1'b1; a = 5'd7; b = 5'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset ready", 32'(req_ready), 32'd1);
    chk("midreset valid", 32'(rsp_valid), 32'd0);
    chk("midreset r", 32'(r), 32'd0);
    chk("midreset hi", 32'(hi), 32'd0);
    chk("midreset flags", 32'(flags_out), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("after reset", 1'b0, 5'd6, 5'd3, 5'd0, 5'd2, 5'd0, 5'b00000, 5, 0);
    for (int i = 0; i < 60; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0) ? 5'h10 : 5'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 5'h00 : ($urandom_range(0, 7) == 0) ? 5'h1f : 5'($urandom);
      rf = 5'($urandom);
      model(rop, ra, rb, rf, er, ehi, efl, lat);
      run($sformatf("rand%0d", i), rop, ra, rb, rf, er, ehi, efl, lat, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule
